// File: rtl/apb_pkg.sv
// Shared types and helpers for the parametrised APB completer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Wait-state counter width; covers WAIT_STATES up to 15.
    localparam int CNT_W = 4;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    // Number of byte-offset address bits below the word index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// Register file: strobe-masked write port, combinational read port,
// constant read-only register 0 and a flat export of every register.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = '0,
    localparam int                   IDX_W      = $clog2(NUM_REGS),
    localparam int                   STRB_W     = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [IDX_W-1:0]               widx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [STRB_W-1:0]              wstrb,
    input  logic [IDX_W-1:0]               ridx,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    // Register 0 has no storage; it always reads ID_VALUE.
    logic [NUM_REGS-1:1][DATA_WIDTH-1:0] mem;

    // Byte-masked write into the writable registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we && (widx != '0)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = (ridx == '0) ? ID_VALUE : mem[ridx];

    assign regs_flat[0 +: DATA_WIDTH] = ID_VALUE;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_export
        assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end

endmodule

// File: rtl/apb_param_slave.sv
// Parametrised APB4 completer: address decode, transfer FSM and wait-state
// counter; storage lives in apb_regfile.
//
// state  | meaning
// IDLE   | no transfer; waiting for a setup phase (psel & !penable)
// SETUP  | latch index, direction and error flag; clear wait count
// ACCESS | count wait states, then complete with pready
module apb_param_slave
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA5B0_0001)
) (
    input  logic                           pclk,
    input  logic                           prst,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int                    ADDR_LSB    = addr_lsb(DATA_WIDTH);
    localparam int                    IDX_W       = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'((1 << ADDR_LSB) - 1);
    localparam logic [63:0]           RANGE_BYTES = 64'(NUM_REGS * (DATA_WIDTH / 8));
    localparam logic [CNT_W-1:0]      WAIT_LAST   = CNT_W'(WAIT_STATES);

    apb_state_t             state;
    logic [CNT_W-1:0]       wait_cnt;
    logic [IDX_W-1:0]       lat_idx;
    logic                   lat_write;
    logic                   lat_err;

    logic [IDX_W-1:0]       idx_dec;
    logic                   err_dec;
    logic                   done;
    logic                   we;
    logic [DATA_WIDTH-1:0]  rd_word;

    // Address decode is evaluated while in SETUP, when paddr/pwrite are stable.
    assign idx_dec = paddr[ADDR_LSB +: IDX_W];
    assign err_dec = ((paddr & ALIGN_MASK) != '0)
                   || (64'(paddr) >= RANGE_BYTES)
                   || (pwrite && (idx_dec == '0));

    assign pready = (state == ACCESS) && (wait_cnt == WAIT_LAST);
    assign done   = pready && psel && penable;
    assign we     = done && lat_write && !lat_err;

    // Transfer sequencing; psel dropping mid-transfer aborts back to IDLE.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt  <= '0;
                    lat_idx   <= idx_dec;
                    lat_write <= pwrite;
                    lat_err   <= err_dec;
                    state     <= psel ? ACCESS : IDLE;
                end
                ACCESS: begin
                    if (!psel) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (!pready) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end else if (penable) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .clk       (pclk),
        .rst       (prst),
        .we        (we),
        .widx      (lat_idx),
        .wdata     (pwdata),
        .wstrb     (pstrb),
        .ridx      (lat_idx),
        .rdata     (rd_word),
        .regs_flat (regs_o)
    );

    assign prdata  = ((state == ACCESS) && !lat_write && !lat_err) ? rd_word : '0;
    assign pslverr = (pready && lat_err) ? RESP_ERROR : RESP_OKAY;

endmodule
